// File: rtl/apb_master.sv
// APB initiator: turns single-beat application commands into APB SETUP/ACCESS
// transfers. It handles wait states and slave errors, and aborts on a programmable timeout.
`timescale 1ns/1ps
module apb_master #(
    parameter int DATA_WD = 32,
    parameter int ADDR_WD = 16,
    parameter int TIMEOUT = 256
) (
    input  logic                 PCLK,
    input  logic                 PRESET,
    input  logic                 CMD_VALID,
    output logic                 CMD_READY,
    input  logic                 CMD_WRITE,
    input  logic [ADDR_WD-1:0]   CMD_ADDR,
    input  logic [DATA_WD-1:0]   CMD_WDATA,
    input  logic [DATA_WD/8-1:0] CMD_STRB,
    output logic                 RSP_VALID,
    output logic [DATA_WD-1:0]   RSP_RDATA,
    output logic [1:0]           RSP_ERR,
    output logic                 RSP_TIMEOUT,
    output logic                 PSEL,
    output logic                 PENABLE,
    output logic                 PWRITE,
    output logic [ADDR_WD-1:0]   PADDR,
    output logic [DATA_WD-1:0]   PWDATA,
    output logic [DATA_WD/8-1:0] PSTRB,
    input  logic                 PREADY,
    input  logic [DATA_WD-1:0]   PRDATA,
    input  logic [1:0]           PSLVERR
);
    localparam int STRB_WD = DATA_WD / 8;
    // A timeout beyond the reach of the saturating 16-bit counter can never fire
    localparam bit          TO_EN   = (TIMEOUT > 0) && (TIMEOUT <= 65536);
    localparam logic [15:0] TO_LAST = TO_EN ? 16'(TIMEOUT - 1) : 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t               state_r, state_next_s;
    logic [15:0]          wait_cnt_r, wait_cnt_next_s;
    logic                 accept_s, done_s, abort_s;
    logic                 cmd_ready_r, rsp_valid_r, rsp_timeout_r;
    logic [DATA_WD-1:0]   rsp_rdata_r, pwdata_r;
    logic [1:0]           rsp_err_r;
    logic                 psel_r, penable_r, pwrite_r;
    logic [ADDR_WD-1:0]   paddr_r;
    logic [STRB_WD-1:0]   pstrb_r;

    // Next-state, wait counter and transfer-termination decode
    always_comb begin
        state_next_s    = state_r;
        wait_cnt_next_s = wait_cnt_r;
        accept_s        = 1'b0;
        done_s          = 1'b0;
        abort_s         = 1'b0;
        case (state_r)
            IDLE: begin
                if (CMD_VALID) begin
                    accept_s        = 1'b1;
                    state_next_s    = SETUP;
                    wait_cnt_next_s = 16'd0;
                end else begin
                    state_next_s = IDLE;
                end
            end
            SETUP: begin
                state_next_s = ACCESS;
            end
            ACCESS: begin
                if (PREADY) begin
                    done_s       = 1'b1;
                    state_next_s = IDLE;
                end else if (TO_EN && (wait_cnt_r == TO_LAST)) begin
                    abort_s      = 1'b1;
                    state_next_s = IDLE;
                end else if (wait_cnt_r != 16'hFFFF) begin
                    wait_cnt_next_s = wait_cnt_r + 16'd1;
                end else begin
                    wait_cnt_next_s = wait_cnt_r;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State, counter and bus control flops; control is derived from the next state
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_r     <= IDLE;
            wait_cnt_r  <= 16'd0;
            cmd_ready_r <= 1'b1;
            psel_r      <= 1'b0;
            penable_r   <= 1'b0;
            rsp_valid_r <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            wait_cnt_r  <= wait_cnt_next_s;
            cmd_ready_r <= (state_next_s == IDLE);
            psel_r      <= (state_next_s != IDLE);
            penable_r   <= (state_next_s == ACCESS);
            rsp_valid_r <= done_s | abort_s;
        end
    end

    // Payload capture on accept and response capture on completion or abort
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            paddr_r       <= {ADDR_WD{1'b0}};
            pwrite_r      <= 1'b0;
            pwdata_r      <= {DATA_WD{1'b0}};
            pstrb_r       <= {STRB_WD{1'b0}};
            rsp_rdata_r   <= {DATA_WD{1'b0}};
            rsp_err_r     <= 2'b00;
            rsp_timeout_r <= 1'b0;
        end else begin
            if (accept_s) begin
                paddr_r  <= CMD_ADDR;
                pwrite_r <= CMD_WRITE;
                pwdata_r <= CMD_WDATA;
                pstrb_r  <= CMD_WRITE ? CMD_STRB : {STRB_WD{1'b0}};
            end
            if (done_s) begin
                rsp_rdata_r   <= pwrite_r ? {DATA_WD{1'b0}} : PRDATA;
                rsp_err_r     <= PSLVERR;
                rsp_timeout_r <= 1'b0;
            end else if (abort_s) begin
                rsp_rdata_r   <= {DATA_WD{1'b0}};
                rsp_err_r     <= 2'b00;
                rsp_timeout_r <= 1'b1;
            end
        end
    end

    assign CMD_READY   = cmd_ready_r;
    assign RSP_VALID   = rsp_valid_r;
    assign RSP_RDATA   = rsp_rdata_r;
    assign RSP_ERR     = rsp_err_r;
    assign RSP_TIMEOUT = rsp_timeout_r;
    assign PSEL        = psel_r;
    assign PENABLE     = penable_r;
    assign PWRITE      = pwrite_r;
    assign PADDR       = paddr_r;
    assign PWDATA      = pwdata_r;
    assign PSTRB       = pstrb_r;
endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: a cycle-by-cycle vector table covering write, wait-state read,
// slave error and back-to-back commands, plus sequences for the timeout and asynchronous reset cases.
`timescale 1ns/1ps
module tb_apb_master;
    logic        PCLK = 1'b0;
    logic        PRESET;
    logic        CMD_VALID, CMD_READY, CMD_WRITE;
    logic [15:0] CMD_ADDR;
    logic [31:0] CMD_WDATA;
    logic [3:0]  CMD_STRB;
    logic        RSP_VALID, RSP_TIMEOUT;
    logic [31:0] RSP_RDATA;
    logic [1:0]  RSP_ERR;
    logic        PSEL, PENABLE, PWRITE;
    logic [15:0] PADDR;
    logic [31:0] PWDATA;
    logic [3:0]  PSTRB;
    logic        PREADY;
    logic [31:0] PRDATA;
    logic [1:0]  PSLVERR;

    int checks = 0;
    int errors = 0;

    always #5 PCLK = ~PCLK;

    apb_master #(.DATA_WD(32), .ADDR_WD(16), .TIMEOUT(8)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_WRITE(CMD_WRITE),
        .CMD_ADDR(CMD_ADDR), .CMD_WDATA(CMD_WDATA), .CMD_STRB(CMD_STRB),
        .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA), .RSP_ERR(RSP_ERR),
        .RSP_TIMEOUT(RSP_TIMEOUT),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB),
        .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR)
    );

    typedef struct packed {
        logic        v;
        logic        w;
        logic [15:0] a;
        logic [31:0] wd;
        logic [3:0]  s;
        logic        rdy;
        logic [31:0] rd;
        logic [1:0]  err;
        logic [95:0] exp;
    } vec_t;

    vec_t vecs[$];

    // Layout: sel en crdy rv | rdata | err | to | addr | wr | wdata | strb
    function automatic logic [95:0] pk(input logic sel, input logic en, input logic crdy,
                                       input logic rv, input logic [31:0] rdata,
                                       input logic [1:0] err, input logic to,
                                       input logic [15:0] addr, input logic wr,
                                       input logic [31:0] wdata, input logic [3:0] strb);
        return {4'b0000, sel, en, crdy, rv, rdata, err, to, addr, wr, wdata, strb};
    endfunction

    function automatic logic [95:0] obs();
        return pk(PSEL, PENABLE, CMD_READY, RSP_VALID, RSP_RDATA, RSP_ERR, RSP_TIMEOUT,
                  PADDR, PWRITE, PWDATA, PSTRB);
    endfunction

    function automatic vec_t mk(input logic v, input logic w, input logic [15:0] a,
                                input logic [31:0] wd, input logic [3:0] s, input logic rdy,
                                input logic [31:0] rd, input logic [1:0] err,
                                input logic [95:0] exp);
        vec_t r;
        r.v = v; r.w = w; r.a = a; r.wd = wd; r.s = s;
        r.rdy = rdy; r.rd = rd; r.err = err; r.exp = exp;
        return r;
    endfunction

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic w, input logic [15:0] a,
                         input logic [31:0] wd, input logic [3:0] s, input logic rdy,
                         input logic [31:0] rd, input logic [1:0] err);
        CMD_VALID = v; CMD_WRITE = w; CMD_ADDR = a; CMD_WDATA = wd; CMD_STRB = s;
        PREADY = rdy; PRDATA = rd; PSLVERR = err;
    endtask

    task automatic tick();
        @(posedge PCLK);
        @(negedge PCLK);
    endtask

    initial begin
        int  n;
        bit  ended;
        int  pulses;

        // Zero-wait write, PRDATA noise must not leak into the write response
        vecs.push_back(mk(1'b1, 1'b1, 16'h0010, 32'hDEADBEEF, 4'hF, 1'b1, 32'hAAAA5555, 2'b00,
            pk(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 16'h0010, 1'b1, 32'hDEADBEEF, 4'hF)));
        vecs.push_back(mk(1'b0, 1'b0, 16'h0000, 32'h0, 4'h0, 1'b1, 32'hAAAA5555, 2'b00,
            pk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 16'h0010, 1'b1, 32'hDEADBEEF, 4'hF)));
        vecs.push_back(mk(1'b0, 1'b0, 16'h0000, 32'h0, 4'h0, 1'b1, 32'hAAAA5555, 2'b00,
            pk(1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 2'b00, 1'b0, 16'h0010, 1'b1, 32'hDEADBEEF, 4'hF)));
        vecs.push_back(mk(1'b0, 1'b0, 16'h0000, 32'h0, 4'h0, 1'b1, 32'h0, 2'b00,
            pk(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 2'b00, 1'b0, 16'h0010, 1'b1, 32'hDEADBEEF, 4'hF)));
        // Read with four wait states: PSTRB forced to 0, ACCESS lasts five cycles
        vecs.push_back(mk(1'b1, 1'b0, 16'h0020, 32'h0, 4'hF, 1'b0, 32'h0, 2'b00,
            pk(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 16'h0020, 1'b0, 32'h0, 4'h0)));
        for (int i = 0; i < 5; i++) begin
            vecs.push_back(mk(1'b0, 1'b0, 16'h0000, 32'h0, 4'h0, 1'b0, 32'h0, 2'b00,
                pk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 16'h0020, 1'b0, 32'h0, 4'h0)));
        end
        vecs.push_back(mk(1'b0, 1'b0, 16'h0000, 32'h0, 4'h0, 1'b1, 32'h12345678, 2'b00,
            pk(1'b0, 1'b0, 1'b1, 1'b1, 32'h12345678, 2'b00, 1'b0, 16'h0020, 1'b0, 32'h0, 4'h0)));
        vecs.push_back(mk(1'b0, 1'b0, 16'h0000, 32'h0, 4'h0, 1'b1, 32'h0, 2'b00,
            pk(1'b0, 1'b0, 1'b1, 1'b0, 32'h12345678, 2'b00, 1'b0, 16'h0020, 1'b0, 32'h0, 4'h0)));
        // Write with slave error; PSLVERR on wait cycles must be ignored
        vecs.push_back(mk(1'b1, 1'b1, 16'h0030, 32'h0BADF00D, 4'h3, 1'b0, 32'h0, 2'b01,
            pk(1'b1, 1'b0, 1'b0, 1'b0, 32'h12345678, 2'b00, 1'b0, 16'h0030, 1'b1, 32'h0BADF00D, 4'h3)));
        for (int i = 0; i < 2; i++) begin
            vecs.push_back(mk(1'b0, 1'b0, 16'h0000, 32'h0, 4'h0, 1'b0, 32'h0, 2'b01,
                pk(1'b1, 1'b1, 1'b0, 1'b0, 32'h12345678, 2'b00, 1'b0, 16'h0030, 1'b1, 32'h0BADF00D, 4'h3)));
        end
        vecs.push_back(mk(1'b0, 1'b0, 16'h0000, 32'h0, 4'h0, 1'b1, 32'hFFFFFFFF, 2'b10,
            pk(1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 2'b10, 1'b0, 16'h0030, 1'b1, 32'h0BADF00D, 4'h3)));
        // Back-to-back with CMD_VALID held: accept during the error response pulse
        vecs.push_back(mk(1'b1, 1'b1, 16'h0040, 32'h11112222, 4'hF, 1'b1, 32'h0, 2'b00,
            pk(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 2'b10, 1'b0, 16'h0040, 1'b1, 32'h11112222, 4'hF)));
        vecs.push_back(mk(1'b1, 1'b0, 16'h0050, 32'h33334444, 4'hF, 1'b1, 32'h0, 2'b00,
            pk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 2'b10, 1'b0, 16'h0040, 1'b1, 32'h11112222, 4'hF)));
        vecs.push_back(mk(1'b1, 1'b0, 16'h0050, 32'h33334444, 4'hF, 1'b1, 32'h99999999, 2'b00,
            pk(1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 2'b00, 1'b0, 16'h0040, 1'b1, 32'h11112222, 4'hF)));
        vecs.push_back(mk(1'b1, 1'b0, 16'h0050, 32'h33334444, 4'hF, 1'b1, 32'hCAFEF00D, 2'b00,
            pk(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 16'h0050, 1'b0, 32'h33334444, 4'h0)));
        vecs.push_back(mk(1'b0, 1'b0, 16'h0000, 32'h0, 4'h0, 1'b1, 32'hCAFEF00D, 2'b00,
            pk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 16'h0050, 1'b0, 32'h33334444, 4'h0)));
        vecs.push_back(mk(1'b0, 1'b0, 16'h0000, 32'h0, 4'h0, 1'b1, 32'hCAFEF00D, 2'b00,
            pk(1'b0, 1'b0, 1'b1, 1'b1, 32'hCAFEF00D, 2'b00, 1'b0, 16'h0050, 1'b0, 32'h33334444, 4'h0)));
        vecs.push_back(mk(1'b0, 1'b0, 16'h0000, 32'h0, 4'h0, 1'b1, 32'h0, 2'b00,
            pk(1'b0, 1'b0, 1'b1, 1'b0, 32'hCAFEF00D, 2'b00, 1'b0, 16'h0050, 1'b0, 32'h33334444, 4'h0)));

        PRESET = 1'b1;
        drive(1'b0, 1'b0, 16'h0000, 32'h0, 4'h0, 1'b0, 32'h0, 2'b00);
        repeat (2) @(negedge PCLK);
        check("reset_state", obs(),
              pk(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 2'b00, 1'b0, 16'h0, 1'b0, 32'h0, 4'h0));
        PRESET = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i].v, vecs[i].w, vecs[i].a, vecs[i].wd, vecs[i].s,
                  vecs[i].rdy, vecs[i].rd, vecs[i].err);
            tick();
            check($sformatf("vec%0d", i), obs(), vecs[i].exp);
        end

        // Timeout: PREADY held low, eight ACCESS cycles then an abort response
        drive(1'b1, 1'b0, 16'h0060, 32'h0, 4'hF, 1'b0, 32'hDEADDEAD, 2'b11);
        tick();
        check("to_setup", obs(),
              pk(1'b1, 1'b0, 1'b0, 1'b0, 32'hCAFEF00D, 2'b00, 1'b0, 16'h0060, 1'b0, 32'h0, 4'h0));
        CMD_VALID = 1'b0;
        n = 0;
        ended = 1'b0;
        for (int i = 0; i < 40 && !ended; i++) begin
            tick();
            if (PSEL && PENABLE) n++;
            else ended = 1'b1;
        end
        check_int("to_budget", int'(ended), 1);
        check_int("to_access_cycles", n, 8);
        check("to_response", obs(),
              pk(1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 2'b00, 1'b1, 16'h0060, 1'b0, 32'h0, 4'h0));
        tick();
        check("to_after", obs(),
              pk(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 2'b00, 1'b1, 16'h0060, 1'b0, 32'h0, 4'h0));

        // PREADY arriving on the would-be timeout cycle completes normally
        drive(1'b1, 1'b0, 16'h0070, 32'h0, 4'hF, 1'b0, 32'h0, 2'b00);
        tick();
        CMD_VALID = 1'b0;
        repeat (8) tick();
        check("win_still_access", obs(),
              pk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 2'b00, 1'b1, 16'h0070, 1'b0, 32'h0, 4'h0));
        PREADY = 1'b1;
        PRDATA = 32'h55AA55AA;
        tick();
        check("win_response", obs(),
              pk(1'b0, 1'b0, 1'b1, 1'b1, 32'h55AA55AA, 2'b00, 1'b0, 16'h0070, 1'b0, 32'h0, 4'h0));

        // Asynchronous reset in the middle of ACCESS
        drive(1'b1, 1'b1, 16'h0080, 32'h01020304, 4'hF, 1'b0, 32'h0, 2'b00);
        tick();
        CMD_VALID = 1'b0;
        tick();
        check("rst_pre_access", obs(),
              pk(1'b1, 1'b1, 1'b0, 1'b0, 32'h55AA55AA, 2'b00, 1'b0, 16'h0080, 1'b1, 32'h01020304, 4'hF));
        #2 PRESET = 1'b1;
        #1 check("rst_async", obs(),
                 pk(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 2'b00, 1'b0, 16'h0, 1'b0, 32'h0, 4'h0));
        @(negedge PCLK);
        PRESET = 1'b0;
        PREADY = 1'b1;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (RSP_VALID || PSEL) pulses++;
        end
        check_int("rst_no_response", pulses, 0);
        check_int("rst_cmd_ready", int'(CMD_READY), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
